// File: rtl/spi_cmd_queue.sv
// SPI command queue: buffers whole command frames in a FIFO and executes them as
// single cell writes, row fills, full-field clears or score updates.
module spi_cmd_queue #(
  parameter int FRAME_BYTES = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int CELLS       = 768,
  parameter int ROW_LEN     = 32,
  parameter int SCORE_W     = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  input  logic [FRAME_BYTES*8-1:0]      frame_data,
  output logic                          we,
  output logic [ADDR_W-1:0]             waddr,
  output logic [DATA_W-1:0]             wdata,
  output logic [SCORE_W-1:0]            score,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          bad_cmd
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, EXEC_WR, EXEC_FILL} state_e;

  logic [31:0]         mem [FIFO_DEPTH];
  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                overflow_q, overflow_d;
  logic                bad_cmd_q, bad_cmd_d;

  logic                push, pop;
  logic [31:0]         in_word, head;
  logic [7:0]          cmd;
  logic [15:0]         arg;
  logic [7:0]          dat;
  logic                unused_bits;

  // Only the top four bytes of a frame carry meaning.
  assign in_word     = frame_data[FRAME_BYTES*8-1 -: 32];
  assign head        = mem[rd_ptr_q];
  assign cmd         = head[31:24];
  assign arg         = head[23:8];
  assign dat         = head[7:0];
  assign unused_bits = ^{frame_data, head};

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign push = frame_valid && ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop);

  // NOTE: payload storage carries no reset; the pointers and count alone define
  // which entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_word;
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    val_d      = val_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    score_d    = score_q;
    overflow_d = overflow_q;
    bad_cmd_d  = bad_cmd_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    if (frame_valid && !push) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) begin
          case (cmd)
            8'h00: ;
            8'h01: begin
              cur_d   = arg[ADDR_W-1:0];
              val_d   = dat[DATA_W-1:0];
              state_d = EXEC_WR;
            end
            8'h02: begin
              cur_d   = arg[ADDR_W-1:0];
              rem_d   = CNT_W'(ROW_LEN);
              val_d   = dat[DATA_W-1:0];
              state_d = EXEC_FILL;
            end
            8'h03: begin
              cur_d   = '0;
              rem_d   = CNT_W'(CELLS);
              val_d   = dat[DATA_W-1:0];
              state_d = EXEC_FILL;
            end
            8'h04:   score_d   = arg[SCORE_W-1:0];
            default: bad_cmd_d = 1'b1;
          endcase
        end
      end
      EXEC_WR: begin
        we_d    = 1'b1;
        waddr_d = cur_q;
        wdata_d = val_q;
        state_d = IDLE;
      end
      EXEC_FILL: begin
        we_d    = 1'b1;
        waddr_d = cur_q;
        wdata_d = val_q;
        // Stop on the count, the last valid cell, or the top of the address space.
        if (rem_q == CNT_W'(1) || cur_q == LAST_CELL || cur_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end else begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_q      <= '0;
      rem_q      <= '0;
      val_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      score_q    <= '0;
      overflow_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      val_q      <= val_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      score_q    <= score_d;
      overflow_q <= overflow_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign score      = score_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign bad_cmd    = bad_cmd_q;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Self-checking bench for spi_cmd_queue: directed table, corner-case sequences and
// randomized frames against a pending-write-list reference model.
module tb_spi_cmd_queue;

  localparam int DEPTH   = 8;
  localparam int CELLS   = 768;
  localparam int ROW_LEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic        we;
  logic [9:0]  waddr;
  logic [7:0]  wdata;
  logic [9:0]  score;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        bad_cmd;

  spi_cmd_queue dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
    .we(we), .waddr(waddr), .wdata(wdata), .score(score), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_we     = 0;
  int peak     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frames waiting, plus the list of writes the current command
  // still owes. One owed write retires per clock; a new frame is taken only when
  // nothing is owed.
  typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
  logic [31:0] mq[$];
  wr_t         pend[$];
  logic        m_we, m_ovf, m_bad;
  logic [9:0]  m_waddr, m_score;
  logic [7:0]  m_wdata;

  task automatic model_reset();
    mq.delete(); pend.delete();
    m_we = 0; m_ovf = 0; m_bad = 0; m_waddr = 0; m_score = 0; m_wdata = 0;
  endtask

  task automatic add_fill(input int start, input int n, input logic [7:0] d);
    int limit, k;
    limit = (start < CELLS) ? CELLS : 1024;
    k = (n < limit - start) ? n : limit - start;
    for (int i = 0; i < k; i++) pend.push_back('{a: 10'(start + i), d: d});
  endtask

  task automatic decode(input logic [31:0] f);
    logic [15:0] arg;
    arg = f[23:8];
    case (f[31:24])
      8'h00: ;
      8'h01: pend.push_back('{a: arg[9:0], d: f[7:0]});
      8'h02: add_fill(int'(arg[9:0]), ROW_LEN, f[7:0]);
      8'h03: add_fill(0, CELLS, f[7:0]);
      8'h04: m_score = arg[9:0];
      default: m_bad = 1;
    endcase
  endtask

  task automatic model_edge(input logic fv, input logic [31:0] fd);
    bit  pop, acc;
    wr_t w;
    pop = (pend.size() == 0) && (mq.size() != 0);
    acc = fv && ((mq.size() < DEPTH) || pop);
    if (pend.size() != 0) begin
      w = pend.pop_front();
      m_we = 1; m_waddr = w.a; m_wdata = w.d;
    end else begin
      m_we = 0;
    end
    if (pop) decode(mq.pop_front());
    if (acc) mq.push_back(fd);
    else if (fv) m_ovf = 1;
  endtask

  function automatic bit m_busy();
    return (pend.size() != 0) || (mq.size() != 0);
  endfunction

  task automatic compare_all();
    check("we", 32'(we), 32'(m_we));
    check("waddr", 32'(waddr), 32'(m_waddr));
    check("wdata", 32'(wdata), 32'(m_wdata));
    check("score", 32'(score), 32'(m_score));
    check("busy", 32'(busy), 32'(m_busy()));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("bad_cmd", 32'(bad_cmd), 32'(m_bad));
  endtask

  // One clock: drive at negedge, model the edge, sample at the next negedge.
  task automatic step(input logic fv, input logic [31:0] fd);
    frame_valid = fv;
    frame_data  = fd;
    @(posedge clk);
    model_edge(fv, fd);
    @(negedge clk);
    frame_valid = 1'b0;
    compare_all();
    if (we === 1'b1) n_we++;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", {we, waddr, wdata, score, busy, fifo_count, overflow, bad_cmd}, 32'h0);
    reset = 1'b0;
    n_we = 0;
    peak = 0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && m_busy(); i++) step(1'b0, 32'h0);
    check("drain_idle", 32'(busy), 32'h0);
  endtask

  function automatic logic [31:0] rand_frame();
    int r;
    logic [31:0] lo;
    r  = $urandom_range(0, 99);
    lo = $urandom;
    if (r < 5)  return {8'h00, lo[23:0]};
    if (r < 45) return {8'h01, 6'($urandom), 10'($urandom_range(0, CELLS-1)), lo[7:0]};
    if (r < 65) begin
      if (r < 55) return {8'h02, 6'h0, 10'($urandom_range(CELLS-40, CELLS-1)), lo[7:0]};
      return {8'h02, 6'h0, 10'($urandom_range(0, CELLS-1)), lo[7:0]};
    end
    if (r < 66) return {8'h03, lo[23:0]};
    if (r < 80) return {8'h04, lo[23:0]};
    return {8'($urandom_range(5, 255)), lo[23:0]};
  endfunction

  typedef struct {
    logic        fv;
    logic [31:0] frame;
    logic        we;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic [9:0]  score;
    logic        busy;
    logic [3:0]  count;
    logic        bad;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 32'h0101235A, 1'b0, 10'h000, 8'h00, 10'h000, 1'b1, 4'd1, 1'b0};
    vecs[1] = '{1'b0, 32'h00000000, 1'b0, 10'h000, 8'h00, 10'h000, 1'b1, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 32'h00000000, 1'b1, 10'h123, 8'h5A, 10'h000, 1'b0, 4'd0, 1'b0};
    vecs[3] = '{1'b0, 32'h00000000, 1'b0, 10'h123, 8'h5A, 10'h000, 1'b0, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 32'h0403FF00, 1'b0, 10'h123, 8'h5A, 10'h000, 1'b1, 4'd1, 1'b0};
    vecs[5] = '{1'b1, 32'h7E000000, 1'b0, 10'h123, 8'h5A, 10'h3FF, 1'b1, 4'd1, 1'b0};
    vecs[6] = '{1'b1, 32'h01000142, 1'b0, 10'h123, 8'h5A, 10'h3FF, 1'b1, 4'd1, 1'b1};
    vecs[7] = '{1'b0, 32'h00000000, 1'b0, 10'h123, 8'h5A, 10'h3FF, 1'b1, 4'd0, 1'b1};
    vecs[8] = '{1'b0, 32'h00000000, 1'b1, 10'h001, 8'h42, 10'h3FF, 1'b0, 4'd0, 1'b1};
    vecs[9] = '{1'b0, 32'h00000000, 1'b0, 10'h001, 8'h42, 10'h3FF, 1'b0, 4'd0, 1'b1};

    @(negedge clk);
    do_reset();

    // WRITE latency, SET_SCORE, undefined opcode, then a WRITE that still runs.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].fv, vecs[i].frame);
      check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
      check($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vecs[i].waddr));
      check($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(vecs[i].wdata));
      check($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].score));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].count));
      check($sformatf("vec%0d_bad", i), 32'(bad_cmd), 32'(vecs[i].bad));
    end

    // FILL_ROW near the end of the field clamps at the last cell.
    do_reset();
    step(1'b1, 32'h0202F007);
    drain(100);
    check("fill_clamp_writes", 32'(n_we), 32'd16);
    check("fill_clamp_last", 32'(waddr), 32'h2FF);
    check("fill_clamp_data", 32'(wdata), 32'h07);

    // CLEAR followed by a burst of nine WRITEs: one is dropped.
    do_reset();
    step(1'b1, 32'h03000000);
    for (int i = 0; i < 9; i++) step(1'b1, {8'h01, 8'h03, 8'(i), 8'(i + 1)});
    drain(2000);
    check("burst_peak", 32'(peak), 32'd8);
    check("burst_overflow", 32'(overflow), 32'h1);
    check("burst_writes", 32'(n_we), 32'd776);

    // Full FIFO: a frame arriving on the pop edge is accepted.
    do_reset();
    step(1'b1, 32'h02000001);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00000000);
    check("full_count", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 100 && pend.size() != 0; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h01000299);
    check("full_pop_push_ovf", 32'(overflow), 32'h0);
    check("full_pop_push_cnt", 32'(fifo_count), 32'd8);
    drain(100);
    check("full_writes", 32'(n_we), 32'd33);

    // Reset in the middle of a CLEAR.
    do_reset();
    step(1'b1, 32'h030000AA);
    step(1'b1, 32'h010000FF);
    for (int i = 0; i < 200 && !(m_we && m_waddr == 10'd100); i++) step(1'b0, 32'h0);
    check("midclear_at100", 32'(waddr), 32'd100);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("midclear_we", 32'(we), 32'h0);
    check("midclear_count", 32'(fifo_count), 32'h0);
    check("midclear_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n_we = 0;
    repeat (40) step(1'b0, 32'h0);
    check("midclear_no_writes", 32'(n_we), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 40) step(1'b1, rand_frame());
      else step(1'b0, 32'h0);
    end
    drain(8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
